// File: rtl/eth_stats_counter.sv
// Ethernet TX/RX statistics monitor: byte, good and bad frame counters.
// Define ETH_STATS_SATURATE_EN to make the 64-bit counters saturate.
module eth_stats_counter #(
    parameter int unsigned MIN_FRAME_LEN = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        srst,
    input  logic        tx_tvalid,
    input  logic        tx_tready,
    input  logic        tx_tlast,
    input  logic        tx_tuser,
    input  logic        rx_tvalid,
    input  logic        rx_tready,
    input  logic        rx_tlast,
    input  logic        rx_tuser,
    output logic [5:0]  stats_id,
    output logic [63:0] tx_bytes,
    output logic [63:0] tx_good,
    output logic [63:0] tx_bad,
    output logic [63:0] rx_bytes,
    output logic [63:0] rx_good,
    output logic [63:0] rx_bad
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SKIP  = 2'd2
    } state_t;

    // Index 0 is TX, index 1 is RX.
    logic        beat [2];
    logic        last [2];
    logic        user [2];

    state_t      state_q [2];
    state_t      state_d [2];
    logic [15:0] len_q   [2];
    logic [15:0] len_d   [2];
    logic        err_q   [2];
    logic        err_d   [2];

    logic        cm      [2];
    logic [15:0] cm_len  [2];
    logic        cm_bad  [2];

    logic [63:0] bytes_q [2];
    logic [63:0] bytes_d [2];
    logic [63:0] good_q  [2];
    logic [63:0] good_d  [2];
    logic [63:0] bad_q   [2];
    logic [63:0] bad_d   [2];
    logic [5:0]  id_q;
    logic [5:0]  id_d;

    assign beat[0] = tx_tvalid & tx_tready;
    assign beat[1] = rx_tvalid & rx_tready;
    assign last[0] = tx_tlast;
    assign last[1] = rx_tlast;
    assign user[0] = tx_tuser;
    assign user[1] = rx_tuser;

    function automatic logic too_short(input logic [15:0] l);
        return (MIN_FRAME_LEN != 0) && ({16'b0, l} < MIN_FRAME_LEN);
    endfunction

    function automatic logic [63:0] add64(input logic [63:0] a,
                                          input logic [63:0] b);
`ifdef ETH_STATS_SATURATE_EN
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[64] ? '1 : s[63:0];
`else
        return a + b;
`endif
    endfunction

    // Per-direction frame FSM: length/error tracking and commit request.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic [15:0] nlen;
            logic        nerr;
            state_d[i] = state_q[i];
            len_d[i]   = len_q[i];
            err_d[i]   = err_q[i];
            cm[i]      = 1'b0;
            cm_len[i]  = len_q[i];
            cm_bad[i]  = 1'b0;
            nlen = (len_q[i] == 16'hFFFF) ? len_q[i] : len_q[i] + 16'd1;
            nerr = err_q[i] | user[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (beat[i] && enable) begin
                        if (last[i]) begin
                            cm[i]     = 1'b1;
                            cm_len[i] = 16'd1;
                            cm_bad[i] = user[i] | too_short(16'd1);
                        end else begin
                            state_d[i] = S_COUNT;
                            len_d[i]   = 16'd1;
                            err_d[i]   = user[i];
                        end
                    end else if (beat[i] && !last[i]) begin
                        state_d[i] = S_SKIP;
                    end
                end
                S_COUNT: begin
                    if (beat[i]) begin
                        if (last[i]) begin
                            cm[i]      = 1'b1;
                            cm_len[i]  = nlen;
                            cm_bad[i]  = nerr | too_short(nlen);
                            state_d[i] = S_IDLE;
                            len_d[i]   = 16'd0;
                            err_d[i]   = 1'b0;
                        end else begin
                            len_d[i] = nlen;
                            err_d[i] = nerr;
                        end
                    end
                end
                S_SKIP: begin
                    if (beat[i] && last[i]) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Counter next-state: apply commits; one id step per update cycle.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bytes_d[i] = bytes_q[i];
            good_d[i]  = good_q[i];
            bad_d[i]   = bad_q[i];
            if (cm[i]) begin
                bytes_d[i] = add64(bytes_q[i], {48'b0, cm_len[i]});
                if (cm_bad[i]) begin
                    bad_d[i] = add64(bad_q[i], 64'd1);
                end else begin
                    good_d[i] = add64(good_q[i], 64'd1);
                end
            end
        end
        id_d = id_q + {5'b0, (cm[0] | cm[1])};
    end

    // State and counter registers; hard or soft reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n || srst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_IDLE;
                len_q[i]   <= '0;
                err_q[i]   <= 1'b0;
                bytes_q[i] <= '0;
                good_q[i]  <= '0;
                bad_q[i]   <= '0;
            end
            id_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                len_q[i]   <= len_d[i];
                err_q[i]   <= err_d[i];
                bytes_q[i] <= bytes_d[i];
                good_q[i]  <= good_d[i];
                bad_q[i]   <= bad_d[i];
            end
            id_q <= id_d;
        end
    end

    assign stats_id = id_q;
    assign tx_bytes = bytes_q[0];
    assign tx_good  = good_q[0];
    assign tx_bad   = bad_q[0];
    assign rx_bytes = bytes_q[1];
    assign rx_good  = good_q[1];
    assign rx_bad   = bad_q[1];

endmodule

// File: tb/tb_eth_stats_counter.sv
// Directed bench for eth_stats_counter.
// Instance a uses MIN_FRAME_LEN=0, instance b uses MIN_FRAME_LEN=64.
module tb_eth_stats_counter;

    logic clk = 1'b0;
    logic rst_n, enable, srst;
    logic tx_tvalid, tx_tready, tx_tlast, tx_tuser;
    logic rx_tvalid, rx_tready, rx_tlast, rx_tuser;

    logic [5:0]  a_id, b_id;
    logic [63:0] a_txb, a_txg, a_txe, a_rxb, a_rxg, a_rxe;
    logic [63:0] b_txb, b_txg, b_txe, b_rxb, b_rxg, b_rxe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eth_stats_counter #(.MIN_FRAME_LEN(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .srst(srst),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .stats_id(a_id),
        .tx_bytes(a_txb), .tx_good(a_txg), .tx_bad(a_txe),
        .rx_bytes(a_rxb), .rx_good(a_rxg), .rx_bad(a_rxe)
    );

    eth_stats_counter #(.MIN_FRAME_LEN(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .srst(srst),
        .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .tx_tlast(tx_tlast), .tx_tuser(tx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
        .stats_id(b_id),
        .tx_bytes(b_txb), .tx_good(b_txg), .tx_bad(b_txe),
        .rx_bytes(b_rxb), .rx_good(b_rxg), .rx_bad(b_rxe)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive TX/RX frames aligned on byte 1; optional enable change at ev_at.
    task automatic send(input int ntx, input int nrx,
                        input int txe, input int rxe,
                        input int ev_at, input logic ev_en);
        int n;
        n = (ntx > nrx) ? ntx : nrx;
        for (int b = 1; b <= n; b++) begin
            @(negedge clk);
            if (b == ev_at) enable = ev_en;
            tx_tvalid = (b <= ntx);
            tx_tlast  = (b == ntx);
            tx_tuser  = (b == txe);
            rx_tvalid = (b <= nrx);
            rx_tlast  = (b == nrx);
            rx_tuser  = (b == rxe);
        end
        @(negedge clk);
        tx_tvalid = 1'b0; tx_tlast = 1'b0; tx_tuser = 1'b0;
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tuser = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; srst = 1'b0;
        tx_tvalid = 1'b0; tx_tready = 1'b1; tx_tlast = 1'b0; tx_tuser = 1'b0;
        rx_tvalid = 1'b0; rx_tready = 1'b1; rx_tlast = 1'b0; rx_tuser = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_id", {58'b0, a_id}, 64'd0);
        chk("rst_txb", a_txb, 64'd0);
        chk("rst_rxg", a_rxg, 64'd0);
        chk("rst_b_txe", b_txe, 64'd0);
        rst_n = 1'b1;

        // 64-byte good TX frame
        send(64, 0, 0, 0, 0, 1'b1);
        chk("t1_txb", a_txb, 64'd64);
        chk("t1_txg", a_txg, 64'd1);
        chk("t1_txe", a_txe, 64'd0);
        chk("t1_id", {58'b0, a_id}, 64'd1);
        chk("t1_b_txg", b_txg, 64'd1);

        // 100-byte RX frame, error on byte 50
        send(0, 100, 0, 50, 0, 1'b1);
        chk("t2_rxb", a_rxb, 64'd100);
        chk("t2_rxe", a_rxe, 64'd1);
        chk("t2_rxg", a_rxg, 64'd0);
        chk("t2_id", {58'b0, a_id}, 64'd2);

        // TX and RX 40-byte frames ending together
        send(40, 40, 0, 0, 0, 1'b1);
        chk("t3_txb", a_txb, 64'd104);
        chk("t3_txg", a_txg, 64'd2);
        chk("t3_rxb", a_rxb, 64'd140);
        chk("t3_rxg", a_rxg, 64'd1);
        chk("t3_id", {58'b0, a_id}, 64'd3);
        chk("t3_b_txe", b_txe, 64'd1);
        chk("t3_b_rxe", b_rxe, 64'd2);
        chk("t3_b_id", {58'b0, b_id}, 64'd3);

        // Frame starting while disabled is never counted
        enable = 1'b0;
        send(60, 0, 0, 0, 10, 1'b1);
        chk("t4_skip_txb", a_txb, 64'd104);
        chk("t4_skip_id", {58'b0, a_id}, 64'd3);
        send(64, 0, 0, 0, 0, 1'b1);
        chk("t4_next_txb", a_txb, 64'd168);
        chk("t4_next_txg", a_txg, 64'd3);
        chk("t4_next_id", {58'b0, a_id}, 64'd4);

        // 63-byte good frame is short for instance b
        send(63, 0, 0, 0, 0, 1'b1);
        chk("t5_b_txe", b_txe, 64'd2);
        chk("t5_b_txb", b_txb, 64'd231);
        chk("t5_a_txg", a_txg, 64'd4);
        chk("t5_id", {58'b0, b_id}, 64'd5);

        // Back-to-back 1-byte frames, stats_id wraps 63 -> 0
        for (int k = 0; k < 58; k++) begin
            @(negedge clk);
            tx_tvalid = 1'b1; tx_tlast = 1'b1;
        end
        @(negedge clk);
        tx_tvalid = 1'b0; tx_tlast = 1'b0;
        chk("t5_id63", {58'b0, b_id}, 64'd63);
        send(1, 0, 0, 0, 0, 1'b1);
        chk("t5_wrap_a", {58'b0, a_id}, 64'd0);
        chk("t5_wrap_b", {58'b0, b_id}, 64'd0);
        chk("t5_a_txg", a_txg, 64'd63);
        chk("t5_a_txb", a_txb, 64'd290);
        chk("t5_b_txe2", b_txe, 64'd61);

        // Soft reset at byte 20 of an 80-byte frame
        for (int b = 1; b <= 80; b++) begin
            @(negedge clk);
            if (b == 21) begin
                chk("t6_clr_txb", a_txb, 64'd0);
                chk("t6_clr_rxb", a_rxb, 64'd0);
                chk("t6_clr_id", {58'b0, a_id}, 64'd0);
                chk("t6_clr_b_txe", b_txe, 64'd0);
            end
            srst      = (b == 20);
            tx_tvalid = 1'b1;
            tx_tlast  = (b == 80);
        end
        @(negedge clk);
        tx_tvalid = 1'b0; tx_tlast = 1'b0;
        chk("t6_txb", a_txb, 64'd60);
        chk("t6_txg", a_txg, 64'd1);
        chk("t6_id", {58'b0, a_id}, 64'd1);
        chk("t6_b_txe", b_txe, 64'd1);

        // Enable dropping mid-frame does not abort it
        send(30, 0, 0, 0, 5, 1'b0);
        enable = 1'b1;
        chk("t7_txb", a_txb, 64'd90);
        chk("t7_txg", a_txg, 64'd2);
        chk("t7_id", {58'b0, a_id}, 64'd2);
        chk("t7_b_txe", b_txe, 64'd2);

        // srst held during hard reset changes nothing further
        rst_n = 1'b0; srst = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; srst = 1'b0;
        chk("t8_txb", a_txb, 64'd0);
        chk("t8_id", {58'b0, b_id}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
